// File: rtl/simm_pkg.sv
// Shared FSM encodings, SIZ encodings and the 68030 byte-lane decode for the SIMM CPU front end.
package simm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;
    localparam logic [1:0] ST_BERR   = 2'd3;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // Lane bit 3 = D31:24; a 32-bit port sees the operand left-justified at the address offset.
    function automatic logic [3:0] lane_decode(input logic [1:0] siz, input logic [1:0] a);
        logic [3:0] lanes;
        lanes = 4'b0001;
        case (a)
            2'b00: begin
                case (siz)
                    SIZ_BYTE:  lanes = 4'b1000;
                    SIZ_WORD:  lanes = 4'b1100;
                    SIZ_3BYTE: lanes = 4'b1110;
                    default:   lanes = 4'b1111;
                endcase
            end
            2'b01: begin
                case (siz)
                    SIZ_BYTE: lanes = 4'b0100;
                    SIZ_WORD: lanes = 4'b0110;
                    default:  lanes = 4'b0111;
                endcase
            end
            2'b10:   lanes = (siz == SIZ_BYTE) ? 4'b0010 : 4'b0011;
            default: lanes = 4'b0001;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/simm_sync.sv
// Two-flop synchroniser for asynchronous CPU strobes, with a selectable reset value.
module simm_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/simm_cpu_interface.sv
// 68030 bus front end for the SIMM DRAM controller: strobe sync, window decode,
// attribute latching, DSACK termination and BERR on controller timeout.
module simm_cpu_interface
    import simm_pkg::*;
#(
    parameter logic [6:0]  DECODE_BASE    = 7'h01,
    parameter int unsigned BANK_BIT       = 24,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_ds_n,
    input  logic        cpu_rw,
    input  logic [1:0]  cpu_siz,
    input  logic [31:0] cpu_addr,
    input  logic        waitstate,
    output logic        cs,
    output logic        as,
    output logic        ds,
    output logic        rn_w,
    output logic        bank_addr,
    output logic [3:0]  byte_selects,
    output logic [1:0]  dsack_n,
    output logic        berr_n
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic as_n_s, ds_n_s, as_s, ds_s, hit, addr_unused;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          cs_nxt, as_nxt, ds_nxt, rn_w_nxt, bank_nxt, berr_n_nxt;
    logic [3:0]    bsel_nxt;
    logic [1:0]    dsack_n_nxt;

    simm_sync #(.RESET_VAL(1'b1)) u_sync_as (.clock(clock), .reset(reset), .d(cpu_as_n), .q(as_n_s));
    simm_sync #(.RESET_VAL(1'b1)) u_sync_ds (.clock(clock), .reset(reset), .d(cpu_ds_n), .q(ds_n_s));

    assign as_s        = ~as_n_s;
    assign ds_s        = ~ds_n_s;
    assign hit         = (cpu_addr[31:25] == DECODE_BASE);
    assign addr_unused = ^cpu_addr;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cs_nxt      = cs;
        as_nxt      = as;
        ds_nxt      = ds;
        rn_w_nxt    = rn_w;
        bank_nxt    = bank_addr;
        bsel_nxt    = byte_selects;
        dsack_n_nxt = dsack_n;
        berr_n_nxt  = berr_n;
        case (state)
            ST_IDLE: begin
                if (as_s && hit) begin
                    state_nxt = ST_ACTIVE;
                    cs_nxt    = 1'b1;
                    as_nxt    = 1'b1;
                    rn_w_nxt  = cpu_rw;
                    bank_nxt  = cpu_addr[BANK_BIT];
                    bsel_nxt  = lane_decode(cpu_siz, cpu_addr[1:0]);
                    cnt_nxt   = '0;
                end
            end
            ST_ACTIVE: begin
                ds_nxt = ds_s;
                if (cnt != '1) cnt_nxt = cnt + CW'(1);
                // Abort outranks release, and release outranks timeout.
                if (!as_s) begin
                    state_nxt = ST_IDLE;
                end else if (!waitstate) begin
                    state_nxt   = ST_ACK;
                    dsack_n_nxt = 2'b00;
                end else if (cnt == LIMIT) begin
                    state_nxt  = ST_BERR;
                    berr_n_nxt = 1'b0;
                    as_nxt     = 1'b0;
                    ds_nxt     = 1'b0;
                end
            end
            ST_ACK:  if (!as_s) state_nxt = ST_IDLE;
            ST_BERR: if (!as_s) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Every exit to IDLE restores the idle output set in one place.
        if (state != ST_IDLE && state_nxt == ST_IDLE) begin
            cnt_nxt     = '0;
            cs_nxt      = 1'b0;
            as_nxt      = 1'b0;
            ds_nxt      = 1'b0;
            rn_w_nxt    = 1'b1;
            bank_nxt    = 1'b0;
            bsel_nxt    = '0;
            dsack_n_nxt = 2'b11;
            berr_n_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cs           <= 1'b0;
            as           <= 1'b0;
            ds           <= 1'b0;
            rn_w         <= 1'b1;
            bank_addr    <= 1'b0;
            byte_selects <= '0;
            dsack_n      <= 2'b11;
            berr_n       <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cs           <= cs_nxt;
            as           <= as_nxt;
            ds           <= ds_nxt;
            rn_w         <= rn_w_nxt;
            bank_addr    <= bank_nxt;
            byte_selects <= bsel_nxt;
            dsack_n      <= dsack_n_nxt;
            berr_n       <= berr_n_nxt;
        end
    end

endmodule
